chad_io_bridge: RTL

- I/O-side responder for the chad core's io_rd/io_wr strobes.
- Decodes a single-cycle strobe into a req/ack transaction on a slower external peripheral bus.
- Stalls the core through its hold input until read data is ready.
- Writes are posted: the core continues while the bus write runs. Any following access stalls until that write completes.

---
 rtl/chad_io_bridge.sv | 124 ++++++++++++
 1 files changed

// File: rtl/chad_io_bridge.sv
// chad core I/O responder: turns io_rd/io_wr strobes into req/ack
// transactions on a slow peripheral bus, stalling the core via hold.
module chad_io_bridge #(
    parameter int WIDTH   = 18,
    parameter int AW      = 15,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [14:0]      io_addr,
    input  logic [WIDTH-1:0] io_dout,
    output logic [WIDTH-1:0] io_din,
    output logic             hold,
    output logic             bus_req,
    output logic             bus_we,
    output logic [AW-1:0]    bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    input  logic [WIDTH-1:0] bus_rdata,
    input  logic             bus_ack,
    output logic             bus_tmo
);

    typedef enum logic [1:0] {
        IDLE,
        WR_BUSY,
        RD_BUSY,
        RD_DONE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_d;
    logic [15:0] cnt;
    logic        busy;
    logic        expire;
    logic        start_rd;
    logic        start_wr;

    assign busy   = (state == WR_BUSY) || (state == RD_BUSY);
    // Ack in the last allowed cycle counts as a normal completion.
    assign expire = busy && !bus_ack && (cnt == TMO_LAST);

    always_comb begin
        state_d  = state;
        start_rd = 1'b0;
        start_wr = 1'b0;
        hold     = 1'b0;
        unique case (state)
            IDLE: begin
                if (io_rd) begin
                    hold     = 1'b1;
                    start_rd = 1'b1;
                    state_d  = RD_BUSY;
                end else if (io_wr) begin
                    start_wr = 1'b1;
                    state_d  = WR_BUSY;
                end
            end
            WR_BUSY: begin
                hold = io_rd | io_wr;
                if (bus_ack || expire)
                    state_d = IDLE;
            end
            RD_BUSY: begin
                hold = 1'b1;
                if (bus_ack || expire)
                    state_d = RD_DONE;
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_tmo   <= 1'b0;
            cnt       <= '0;
        end else begin
            bus_tmo <= expire;
            if (start_rd || start_wr) begin
                bus_req  <= 1'b1;
                bus_we   <= start_wr;
                bus_addr <= io_addr[AW-1:0];
                cnt      <= '0;
                if (start_wr)
                    bus_wdata <= io_dout;
            end else if (busy) begin
                if (bus_ack || expire)
                    bus_req <= 1'b0;
                else
                    cnt <= cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            io_din <= '0;
        else if (state == RD_BUSY) begin
            if (bus_ack)
                io_din <= bus_rdata;
            else if (expire)
                io_din <= '1;
        end
    end

    logic unused_addr;
    assign unused_addr = ^{io_addr, 1'b0};

endmodule
